jam_ctrl: RTL and testbench

- Top-level sequencer for the job-assignment (JAM) engine.
- Drives the 3-bit state bus of the permutation generator, which holds the current worker->job order and steps it lexicographically.
- For each permutation, it fetches 8 costs from the external cost ROM, accumulates the total, and tracks the minimum total cost and how many permutations reach it.
- Reports MinCost/MatchCount with a one-cycle Valid pulse after the last permutation (7,6,...,0) is evaluated.

---
 rtl/jam_ctrl.sv | 133 +++++++++++++
 tb/tb_jam_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jam_ctrl.sv
// Top-level sequencer for the JAM engine: walks every permutation from the external generator,
// sums eight ROM costs per permutation and tracks the minimum total and how many orders hit it.
module jam_ctrl #(
    parameter int unsigned COST_W = 7,
    parameter int unsigned SUM_W  = 10,
    parameter int unsigned MC_W   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [2:0]        state,
    input  logic [23:0]       perm,
    input  logic              swap_flag,
    output logic [2:0]        W,
    output logic [2:0]        J,
    input  logic [COST_W-1:0] Cost,
    output logic [MC_W-1:0]   MatchCount,
    output logic [SUM_W-1:0]  MinCost,
    output logic              Valid
);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StDin        = 3'd1,
        StMinCostCal = 3'd2,
        StCompare    = 3'd3,
        StSwap       = 3'd4,
        StReOrder    = 3'd5,
        StDone       = 3'd6,
        StIllegal    = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        w_q, w_d, j_q, j_d;
    logic [SUM_W-1:0]  sum_q, sum_d, min_q, min_d;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic              valid_q, valid_d;
    logic [2:0]        nxt_idx;
    logic [4:0]        nxt_base;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            w_q     <= '0;
            j_q     <= '0;
            sum_q   <= '0;
            min_q   <= '1;
            mc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            j_q     <= j_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            mc_q    <= mc_d;
            valid_q <= valid_d;
        end
    end

    // Address for the next counter value is loaded one edge early so that address k is
    // on the bus for the whole cnt=k cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        j_d      = j_q;
        sum_d    = sum_q;
        min_d    = min_q;
        mc_d     = mc_q;
        valid_d  = 1'b0;
        nxt_idx  = cnt_q[2:0] + 3'd1;
        nxt_base = 5'(nxt_idx) * 5'd3;

        case (state_q)
            StDin: begin
                if (cnt_q == 4'd0) begin
                    sum_d = '0;
                end else begin
                    sum_d = sum_q + SUM_W'(Cost);
                end
                if (cnt_q == 4'd8) begin
                    state_d = StMinCostCal;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q < 4'd7) begin
                        w_d = nxt_idx;
                        j_d = perm[nxt_base +: 3];
                    end
                end
            end
            StMinCostCal: begin
                if (sum_q < min_q) begin
                    min_d = sum_q;
                    mc_d  = MC_W'(1);
                end else if (sum_q == min_q && mc_q != {MC_W{1'b1}}) begin
                    mc_d = mc_q + MC_W'(1);
                end
                state_d = StCompare;
            end
            StCompare: begin
                // Without a further permutation the generator's swap is spurious; stop here.
                if (swap_flag) begin
                    state_d = StReOrder;
                end else begin
                    state_d = StDone;
                    valid_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                // Idle, re-order, and the never-issued encodings all restart address fetch.
                state_d = StDin;
                cnt_d   = '0;
                w_d     = '0;
                j_d     = perm[2:0];
            end
        endcase
    end

    assign state      = state_q;
    assign W          = w_q;
    assign J          = j_q;
    assign MinCost    = min_q;
    assign MatchCount = mc_q;
    assign Valid      = valid_q;

endmodule

// File: tb/tb_jam_ctrl.sv
// Directed bench for jam_ctrl: stub generator plus a registered cost ROM model.
module tb_jam_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  state, W, J;
    logic [23:0] perm;
    logic        swap_flag;
    logic [6:0]  Cost;
    logic [3:0]  MatchCount;
    logic [9:0]  MinCost;
    logic        Valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cost_mode = 0;

    jam_ctrl #(.COST_W(7), .SUM_W(10), .MC_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .state      (state),
        .perm       (perm),
        .swap_flag  (swap_flag),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MatchCount (MatchCount),
        .MinCost    (MinCost),
        .Valid      (Valid)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] rom(input logic [2:0] w, input logic [2:0] j);
        case (cost_mode)
            1:       return {1'b0, w, j};
            2:       return (w == j) ? 7'd0 : 7'd10;
            default: return 7'd5;
        endcase
    endfunction

    always @(posedge CLK) Cost <= rom(W, J);

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] ident();
        logic [23:0] p;
        for (int k = 0; k < 8; k++) p[3*k +: 3] = 3'(k);
        return p;
    endfunction

    function automatic logic [23:0] swp(input logic [23:0] p, input int a, input int b);
        logic [23:0] q;
        q = p;
        q[3*a +: 3] = p[3*b +: 3];
        q[3*b +: 3] = p[3*a +: 3];
        return q;
    endfunction

    // Holds RST for two cycles, checks reset values, releases on a falling edge.
    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk({tag, "_rst_state"}, state, 0);
        chk({tag, "_rst_min"}, MinCost, 1023);
        chk({tag, "_rst_mc"}, MatchCount, 0);
        chk({tag, "_rst_valid"}, Valid, 0);
        chk({tag, "_rst_w"}, W, 0);
        chk({tag, "_rst_j"}, J, 0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st);
        int k = 0;
        while (state !== st && k < 200) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, state, st);
    endtask

    // Single-permutation run (swap_flag=0) starting right after reset release.
    task automatic run_single(input string tag, input int exp_min);
        int exp_st;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge CLK);
            exp_st = (c == 0) ? 0 : (c <= 9) ? 1 : (c == 10) ? 2 : (c == 11) ? 3 : 6;
            chk($sformatf("%s_state_c%0d", tag, c), state, exp_st);
            chk($sformatf("%s_valid_c%0d", tag, c), Valid, (c == 12) ? 1 : 0);
            if (c >= 1 && c <= 9) begin
                chk($sformatf("%s_w_c%0d", tag, c), W, (c > 8) ? 7 : c - 1);
                chk($sformatf("%s_j_c%0d", tag, c), J,
                    int'(perm[3*((c > 8) ? 7 : c - 1) +: 3]));
            end
            if (c >= 12) begin
                chk($sformatf("%s_min_c%0d", tag, c), MinCost, exp_min);
                chk($sformatf("%s_mc_c%0d", tag, c), MatchCount, 1);
            end
        end
    endtask

    logic [23:0] evals [5];
    int          exp_min [5];
    int          exp_mc [5];

    initial begin
        perm      = ident();
        swap_flag = 1'b0;

        // Constant cost 5, identity order.
        cost_mode = 0;
        do_reset("t1");
        run_single("t1", 40);

        // Cost = W*8+J; any order totals 8*28 + 28 = 252. Shuffled order exercises J lookup.
        cost_mode = 1;
        perm = {3'd5, 3'd7, 3'd2, 3'd6, 3'd0, 3'd4, 3'd1, 3'd3};
        do_reset("t2");
        run_single("t2", 252);

        // Diagonal costs: lower sum resets count, equal sum increments it.
        cost_mode = 2;
        evals[0] = swp(ident(), 0, 1); exp_min[0] = 20; exp_mc[0] = 1;
        evals[1] = swp(ident(), 1, 2); exp_min[1] = 20; exp_mc[1] = 2;
        evals[2] = ident();            exp_min[2] = 0;  exp_mc[2] = 1;
        evals[3] = swp(ident(), 0, 1); exp_min[3] = 0;  exp_mc[3] = 1;
        evals[4] = ident();            exp_min[4] = 0;  exp_mc[4] = 2;
        perm = evals[0];
        do_reset("t5");
        for (int i = 0; i < 5; i++) begin
            swap_flag = (i < 4);
            wait_state($sformatf("t5_cmp%0d", i), 3);
            chk($sformatf("t5_min%0d", i), MinCost, exp_min[i]);
            chk($sformatf("t5_mc%0d", i), MatchCount, exp_mc[i]);
            chk($sformatf("t5_valid%0d", i), Valid, 0);
            if (i < 4) begin
                wait_state($sformatf("t5_reo%0d", i), 5);
                perm = evals[i+1];
            end
        end
        @(negedge CLK);
        chk("t5_done_state", state, 6);
        chk("t5_done_valid", Valid, 1);
        chk("t5_done_min", MinCost, 0);
        chk("t5_done_mc", MatchCount, 2);
        @(negedge CLK);
        chk("t5_park_valid", Valid, 0);
        chk("t5_park_state", state, 6);

        // 17 tied permutations: MatchCount saturates at 15.
        cost_mode = 0;
        perm = ident();
        do_reset("sat");
        for (int i = 0; i < 17; i++) begin
            swap_flag = (i < 16);
            wait_state($sformatf("sat_cmp%0d", i), 3);
            chk($sformatf("sat_mc%0d", i), MatchCount, (i + 1 > 15) ? 15 : i + 1);
            chk($sformatf("sat_valid%0d", i), Valid, 0);
            if (i < 16) wait_state($sformatf("sat_reo%0d", i), 5);
        end
        @(negedge CLK);
        chk("sat_done_valid", Valid, 1);
        chk("sat_done_min", MinCost, 40);

        // Reset in the middle of the second permutation's fetch (cnt=4).
        swap_flag = 1'b1;
        do_reset("t6");
        wait_state("t6_cmp", 3);
        chk("t6_min_pre", MinCost, 40);
        wait_state("t6_reo", 5);
        wait_state("t6_din", 1);
        repeat (4) @(negedge CLK);
        chk("t6_w_cnt4", W, 4);
        RST = 1'b1;
        #1;
        chk("t6_async_state", state, 0);
        chk("t6_async_min", MinCost, 1023);
        chk("t6_async_mc", MatchCount, 0);
        chk("t6_async_valid", Valid, 0);
        swap_flag = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        run_single("t6", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
